// File: rtl/dsd6_bus_arb.sv
// Two-master bus arbiter: MMU walker (A) and CPU (B) share one bus, round-robin with A-side lock.
// Optional bus-cycle timeout is enabled with `define DSD6_ARB_TIMEOUT_EN.
module dsd6_bus_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_va_i,
  input  logic        a_lock_i,
  input  logic        a_wr_i,
  input  logic [7:0]  a_sel_i,
  input  logic [47:0] a_adr_i,
  input  logic [63:0] a_dat_i,
  output logic        a_rdy_o,
  output logic [63:0] a_dat_o,
  input  logic        b_vda_i,
  input  logic        b_vpa_i,
  input  logic        b_wr_i,
  input  logic [7:0]  b_sel_i,
  input  logic [47:0] b_adr_i,
  input  logic [63:0] b_dat_i,
  output logic        b_rdy_o,
  output logic [63:0] b_dat_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic        lock_o,
  output logic [7:0]  sel_o,
  output logic [47:0] adr_o,
  output logic [63:0] dat_o,
  input  logic        ack_i,
  input  logic [63:0] dat_i,
  output logic        err_o,
  output logic [47:0] err_adr_o
);
  typedef enum logic [1:0] {IDLE, BUS_A, BUS_B, DONE} state_t;

  state_t      r_state, w_nxt;
  logic        r_last;    // 1: A served last, 0: B served last
  logic        r_locked;
  logic        r_cyc, r_stb, r_we, r_a_rdy, r_b_rdy;
  logic [7:0]  r_sel;
  logic [47:0] r_adr;
  logic [63:0] r_dat, r_a_dat, r_b_dat;
  logic        w_a_req, w_b_req, w_lock_eff, w_gnt_a, w_gnt_b, w_end, w_tmo;

  assign w_a_req    = a_va_i;
  assign w_b_req    = b_vda_i | b_vpa_i;
  // The lock is released in the same IDLE cycle that A drops a_lock_i, so B may be granted right away.
  assign w_lock_eff = r_locked & a_lock_i;

`ifdef DSD6_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [47:0]   r_err_adr;
  assign w_tmo     = (r_cnt == CW'(TIMEOUT));
  assign err_o     = r_err;
  assign err_adr_o = r_err_adr;
`else
  assign w_tmo     = 1'b0;
  assign err_o     = 1'b0;
  assign err_adr_o = '0;
`endif

  always_comb begin
    w_nxt   = r_state;
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    w_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_a_req && (!w_b_req || w_lock_eff || !r_last)) begin
          w_gnt_a = 1'b1;
          w_nxt   = BUS_A;
        end else if (w_b_req && !w_lock_eff) begin
          w_gnt_b = 1'b1;
          w_nxt   = BUS_B;
        end
      end
      BUS_A, BUS_B: begin
        if (ack_i || w_tmo) begin
          w_end = 1'b1;
          w_nxt = DONE;
        end
      end
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_last <= 1'b0;  r_locked <= 1'b0;
      r_cyc  <= 1'b0;  r_stb    <= 1'b0;  r_we <= 1'b0;
      r_sel  <= '0;    r_adr    <= '0;    r_dat <= '0;
      r_a_rdy <= 1'b0; r_b_rdy  <= 1'b0;
      r_a_dat <= '0;   r_b_dat  <= '0;
`ifdef DSD6_ARB_TIMEOUT_EN
      r_cnt <= '0; r_err <= 1'b0; r_err_adr <= '0;
`endif
    end else begin
      r_a_rdy <= 1'b0;
      r_b_rdy <= 1'b0;
      if (w_gnt_a) begin
        r_cyc <= 1'b1; r_stb <= 1'b1; r_we <= a_wr_i;
        r_sel <= a_sel_i; r_adr <= a_adr_i; r_dat <= a_dat_i;
      end else if (w_gnt_b) begin
        r_cyc <= 1'b1; r_stb <= 1'b1; r_we <= b_wr_i;
        r_sel <= b_sel_i; r_adr <= b_adr_i; r_dat <= b_dat_i;
      end
      if (r_state == IDLE) begin
        if (w_gnt_a)        r_locked <= a_lock_i;
        else if (!a_lock_i) r_locked <= 1'b0;
      end
      // A timed-out cycle completes like an ack but returns all ones.
      if (w_end) begin
        r_cyc <= 1'b0;
        r_stb <= 1'b0;
        if (r_state == BUS_A) begin
          r_a_rdy <= 1'b1;
          r_a_dat <= ack_i ? dat_i : '1;
          r_last  <= 1'b1;
        end else begin
          r_b_rdy <= 1'b1;
          r_b_dat <= ack_i ? dat_i : '1;
          r_last  <= 1'b0;
        end
      end
`ifdef DSD6_ARB_TIMEOUT_EN
      r_err <= w_end & ~ack_i;
      if (w_end && !ack_i) r_err_adr <= r_adr;
      if (w_gnt_a || w_gnt_b)
        r_cnt <= '0;
      else if ((r_state == BUS_A || r_state == BUS_B) && !w_end)
        r_cnt <= r_cnt + CW'(1);
`endif
    end
  end

  assign cyc_o   = r_cyc;
  assign stb_o   = r_stb;
  assign we_o    = r_we;
  assign lock_o  = r_locked;
  assign sel_o   = r_sel;
  assign adr_o   = r_adr;
  assign dat_o   = r_dat;
  assign a_rdy_o = r_a_rdy;
  assign b_rdy_o = r_b_rdy;
  assign a_dat_o = r_a_dat;
  assign b_dat_o = r_b_dat;
endmodule

// File: tb/tb_dsd6_bus_arb.sv
// Scoreboard bench for dsd6_bus_arb: directed master requests, a bus slave model and a completion monitor.
module tb_dsd6_bus_arb;
  logic        clk_i = 1'b0, rst_i;
  logic        a_va_i, a_lock_i, a_wr_i, b_vda_i, b_vpa_i, b_wr_i;
  logic [7:0]  a_sel_i, b_sel_i, sel_o;
  logic [47:0] a_adr_i, b_adr_i, adr_o, err_adr_o;
  logic [63:0] a_dat_i, b_dat_i, a_dat_o, b_dat_o, dat_o, dat_i;
  logic        a_rdy_o, b_rdy_o, cyc_o, stb_o, we_o, lock_o, ack_i, err_o;

  always #5 clk_i = ~clk_i;

  dsd6_bus_arb #(.TIMEOUT(8)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_va_i(a_va_i), .a_lock_i(a_lock_i), .a_wr_i(a_wr_i), .a_sel_i(a_sel_i),
    .a_adr_i(a_adr_i), .a_dat_i(a_dat_i), .a_rdy_o(a_rdy_o), .a_dat_o(a_dat_o),
    .b_vda_i(b_vda_i), .b_vpa_i(b_vpa_i), .b_wr_i(b_wr_i), .b_sel_i(b_sel_i),
    .b_adr_i(b_adr_i), .b_dat_i(b_dat_i), .b_rdy_o(b_rdy_o), .b_dat_o(b_dat_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .lock_o(lock_o), .sel_o(sel_o),
    .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i),
    .err_o(err_o), .err_adr_o(err_adr_o)
  );

  typedef struct {
    logic        port;  // 1: A, 0: B
    logic [63:0] dat;
    logic [47:0] adr;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave: acks slv_dly strobe cycles late; runs 1ns after negedge to see this cycle's settings.
  logic        slv_en = 1'b0, slv_force = 1'b0, slv_use_adr = 1'b0;
  int          slv_dly = 0;
  logic [63:0] slv_dat = '0;
  initial begin
    int cnt;
    cnt = 0; ack_i = 1'b0; dat_i = '0;
    forever begin
      @(negedge clk_i); #1;
      if (slv_force) ack_i = 1'b1;
      else if (slv_en && stb_o && !ack_i) begin
        if (cnt == slv_dly) begin
          ack_i = 1'b1;
          dat_i = slv_use_adr ? {16'hD00D, adr_o} : slv_dat;
          cnt   = 0;
        end else begin
          ack_i = 1'b0;
          cnt++;
        end
      end else begin
        ack_i = 1'b0;
        cnt   = 0;
      end
    end
  end

  // Monitor: every completion pulse is checked against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (a_rdy_o || b_rdy_o) begin
        chk("rdy_exclusive", 64'(a_rdy_o & b_rdy_o), 64'd0);
        if (q.size() == 0) chk("rdy_unexpected", 64'(a_rdy_o | b_rdy_o), 64'd0);
        else begin
          e = q.pop_front();
          chk("rdy_port", 64'(a_rdy_o), 64'(e.port));
          chk("rdy_dat", e.port ? a_dat_o : b_dat_o, e.dat);
          chk("rdy_adr", 64'(adr_o), 64'(e.adr));
          chk("rdy_err", 64'(err_o), 64'(e.err));
          if (e.err) chk("err_adr", 64'(err_adr_o), 64'(e.adr));
        end
      end
    end
  end

  logic we_chk = 1'b0, we_bad = 1'b0, lock_span = 1'b0, lock_bad = 1'b0;
  always @(negedge clk_i) begin
    if (we_chk && we_o) we_bad = 1'b1;
    if (lock_span && !lock_o) lock_bad = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_rdy(input logic port);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(port ? a_rdy_o : b_rdy_o) && n < 60);
    chk("wait_rdy", 64'(port ? a_rdy_o : b_rdy_o), 64'd1);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    rst_i = 1'b0;
    a_va_i = 0; a_lock_i = 0; a_wr_i = 0; a_sel_i = '0; a_adr_i = '0; a_dat_i = '0;
    b_vda_i = 0; b_vpa_i = 0; b_wr_i = 0; b_sel_i = '0; b_adr_i = '0; b_dat_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ctl", 64'({cyc_o, stb_o, we_o, lock_o, a_rdy_o, b_rdy_o, err_o}), 64'd0);
    chk("rst_sel", 64'(sel_o), 64'd0);
    chk("rst_adr", 64'(adr_o), 64'd0);
    chk("rst_dat", dat_o, 64'd0);
    chk("rst_a_dat", a_dat_o, 64'd0);
    chk("rst_b_dat", b_dat_o, 64'd0);
    chk("rst_err_adr", 64'(err_adr_o), 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // B read, ack after 3 strobe cycles
    slv_en = 1; slv_dly = 3; slv_use_adr = 0; slv_dat = 64'h1122334455667788;
    q.push_back('{1'b0, 64'h1122334455667788, 48'h1000, 1'b0});
    b_vda_i = 1; b_wr_i = 0; b_sel_i = 8'hFF; b_adr_i = 48'h1000; we_chk = 1;
    @(negedge clk_i);
    chk("latency_stb", 64'(stb_o), 64'd1);
    chk("b_read_adr", 64'(adr_o), 64'h1000);
    wait_rdy(1'b0);
    b_vda_i = 0;
    @(negedge clk_i);
    we_chk = 0;
    chk("b_read_rdy_gone", 64'(b_rdy_o), 64'd0);
    chk("b_read_we_low", 64'(we_bad), 64'd0);

    // Simultaneous requests after reset: A first, then B
    do_reset();
    slv_dly = 1; slv_use_adr = 1;
    q.push_back('{1'b1, {16'hD00D, 48'h3000}, 48'h3000, 1'b0});
    q.push_back('{1'b0, {16'hD00D, 48'h4000}, 48'h4000, 1'b0});
    a_va_i = 1; a_wr_i = 1; a_sel_i = 8'h0F; a_adr_i = 48'h3000; a_dat_i = 64'hA5A5;
    b_vpa_i = 1; b_wr_i = 0; b_adr_i = 48'h4000;
    @(negedge clk_i);
    chk("tie_adr_a", 64'(adr_o), 64'h3000);
    chk("tie_we_a", 64'(we_o), 64'd1);
    chk("tie_dat_a", dat_o, 64'hA5A5);
    chk("tie_sel_a", 64'(sel_o), 64'h0F);
    wait_rdy(1'b1);
    a_va_i = 0;
    repeat (2) @(negedge clk_i);
    chk("tie_stb_b", 64'(stb_o), 64'd1);
    chk("tie_adr_b", 64'(adr_o), 64'h4000);
    wait_rdy(1'b0);
    b_vpa_i = 0;
    @(negedge clk_i);

    // Locked A pair holds B off until a_lock_i drops in IDLE
    q.push_back('{1'b1, {16'hD00D, 48'h5000}, 48'h5000, 1'b0});
    q.push_back('{1'b1, {16'hD00D, 48'h7000}, 48'h7000, 1'b0});
    q.push_back('{1'b0, {16'hD00D, 48'h6000}, 48'h6000, 1'b0});
    a_va_i = 1; a_lock_i = 1; a_wr_i = 0; a_adr_i = 48'h5000;
    b_vda_i = 1; b_adr_i = 48'h6000;
    @(negedge clk_i);
    chk("lock_set", 64'(lock_o), 64'd1);
    lock_span = 1;
    wait_rdy(1'b1);
    a_va_i = 0;
    repeat (3) @(negedge clk_i);
    chk("lock_blocks_b", 64'(stb_o), 64'd0);
    a_va_i = 1; a_adr_i = 48'h7000;
    @(negedge clk_i);
    chk("lock_a2_adr", 64'(adr_o), 64'h7000);
    wait_rdy(1'b1);
    a_va_i = 0; a_lock_i = 0; lock_span = 0;
    repeat (2) @(negedge clk_i);
    chk("lock_clr", 64'(lock_o), 64'd0);
    chk("lock_b_adr", 64'(adr_o), 64'h6000);
    chk("lock_b_stb", 64'(stb_o), 64'd1);
    wait_rdy(1'b0);
    b_vda_i = 0;
    @(negedge clk_i);
    chk("lock_span", 64'(lock_bad), 64'd0);

    // Reset during BUS_B aborts; a late ack is ignored
    slv_en = 0;
    b_vda_i = 1; b_adr_i = 48'h8000;
    @(negedge clk_i);
    chk("abort_stb", 64'(stb_o), 64'd1);
    rst_i = 0; b_vda_i = 0;
    @(negedge clk_i);
    chk("abort_cyc", 64'(cyc_o), 64'd0);
    chk("abort_rdy", 64'(b_rdy_o), 64'd0);
    rst_i = 1; slv_force = 1;
    @(negedge clk_i);
    slv_force = 0;
    chk("late_ack_cyc", 64'(cyc_o), 64'd0);
    chk("late_ack_rdy", 64'(b_rdy_o), 64'd0);
    @(negedge clk_i);
    chk("late_ack_dat", b_dat_o, 64'd0);
    chk("late_ack_stb", 64'(stb_o), 64'd0);

`ifdef DSD6_ARB_TIMEOUT_EN
    // Timeout with no ack
    q.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 48'h2000, 1'b1});
    a_va_i = 1; a_wr_i = 1; a_adr_i = 48'h2000; a_dat_i = 64'h55;
    wait_rdy(1'b1);
    a_va_i = 0;
    @(negedge clk_i);
    chk("tmo_err_pulse", 64'(err_o), 64'd0);
    // Ack in the very cycle the count reaches TIMEOUT: ack wins
    slv_en = 1; slv_dly = 8; slv_use_adr = 1;
    q.push_back('{1'b1, {16'hD00D, 48'h2100}, 48'h2100, 1'b0});
    a_va_i = 1; a_wr_i = 0; a_adr_i = 48'h2100;
    wait_rdy(1'b1);
    a_va_i = 0;
    @(negedge clk_i);
`endif

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
